// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the pipeline hazard sequencer: state encoding,
// pipeline NOP encoding, the x0 register index and the load-use test.
package hazard_control_unit_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } hcu_state_e;

   // addi x0, x0, 0 -- what flush/bubble consumers load into a stage register
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [4:0] REG_X0 = 5'd0;

   // Width of the MUL/DIV occupancy down-counter (MD_LATENCY up to 16)
   localparam int MD_CNT_W = 4;

   // A load in EX feeds a register the ID instruction really reads; x0 never hazards
   function automatic logic load_use_hazard(
      input logic       mem_read,
      input logic [4:0] ex_rd,
      input logic [4:0] id_rs1,
      input logic [4:0] id_rs2,
      input logic       uses_rs1,
      input logic       uses_rs2
   );
      return mem_read && (ex_rd != REG_X0) &&
             ((uses_rs1 && (ex_rd == id_rs1)) || (uses_rs2 && (ex_rd == id_rs2)));
   endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-facing signal bundle of the hazard sequencer. The pipeline is the
// master (drives hazard sources, consumes enables); the sequencer is the slave.
interface hazard_control_unit_if #(
   parameter int COUNT_W = 32
);
   logic [4:0]         IF_IDrs1;
   logic [4:0]         IF_IDrs2;
   logic               IF_IDusesRs1;
   logic               IF_IDusesRs2;
   logic [4:0]         ID_EXrd;
   logic               ID_EXmemRead;
   logic               ID_EXmulDiv;
   logic               EX_branchTaken;
   logic               EX_MEMmemAccess;
   logic               dmemReady;

   logic               PCwrite;
   logic               IF_IDwrite;
   logic               ID_EXwrite;
   logic               EX_MEMwrite;
   logic               MEM_WBwrite;
   logic               IF_IDflush;
   logic               ID_EXflush;
   logic               EX_MEMbubble;
   logic               MEM_WBbubble;
   logic               mdStart;
   logic               mdBusy;
   logic [COUNT_W-1:0] stallCycles;

   modport master (
      output IF_IDrs1, IF_IDrs2, IF_IDusesRs1, IF_IDusesRs2, ID_EXrd,
             ID_EXmemRead, ID_EXmulDiv, EX_branchTaken, EX_MEMmemAccess, dmemReady,
      input  PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite, MEM_WBwrite,
             IF_IDflush, ID_EXflush, EX_MEMbubble, MEM_WBbubble,
             mdStart, mdBusy, stallCycles
   );

   modport slave (
      input  IF_IDrs1, IF_IDrs2, IF_IDusesRs1, IF_IDusesRs2, ID_EXrd,
             ID_EXmemRead, ID_EXmulDiv, EX_branchTaken, EX_MEMmemAccess, dmemReady,
      output PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite, MEM_WBwrite,
             IF_IDflush, ID_EXflush, EX_MEMbubble, MEM_WBbubble,
             mdStart, mdBusy, stallCycles
   );
endinterface

// File: rtl/hazard_control_unit_stall_counter.sv
// Saturating performance counter of stalled cycles.
module hazard_stall_counter #(
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   output logic [COUNT_W-1:0] count
);

   // Count enabled cycles, sticking at all-ones instead of wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard sequencer for the 5-stage core: per-cycle advance / hold /
// bubble decisions for memory wait states, MUL/DIV occupancy of EX, taken
// branches and load-use dependencies, plus a stall-cycle counter.
module hazard_control_unit
   import hazard_control_unit_pkg::*;
#(
   parameter int MD_LATENCY = 4,
   parameter int COUNT_W    = 32
) (
   input logic                  clk,
   input logic                  rst,
   hazard_control_unit_if.slave hif
);

   // Cycles still to stall after the entry cycle; only meaningful when MD_LATENCY > 1
   localparam logic [MD_CNT_W-1:0] MD_CNT_INIT = MD_CNT_W'(MD_LATENCY - 2);

   hcu_state_e          state_q;
   hcu_state_e          state_d;
   logic [MD_CNT_W-1:0] md_cnt_q;
   logic [MD_CNT_W-1:0] md_cnt_d;
   logic                mem_wait;
   logic                load_use;
   logic                stall_en;

   assign mem_wait = hif.EX_MEMmemAccess && !hif.dmemReady;
   assign load_use = load_use_hazard(hif.ID_EXmemRead, hif.ID_EXrd, hif.IF_IDrs1,
                                     hif.IF_IDrs2, hif.IF_IDusesRs1, hif.IF_IDusesRs2);

   // Prioritised hazard resolution: enables, flushes and next state
   always_comb begin
      hif.PCwrite      = 1'b1;
      hif.IF_IDwrite   = 1'b1;
      hif.ID_EXwrite   = 1'b1;
      hif.EX_MEMwrite  = 1'b1;
      hif.MEM_WBwrite  = 1'b1;
      hif.IF_IDflush   = 1'b0;
      hif.ID_EXflush   = 1'b0;
      hif.EX_MEMbubble = 1'b0;
      hif.MEM_WBbubble = 1'b0;
      hif.mdStart      = 1'b0;
      hif.mdBusy       = (state_q == MD_BUSY) && !rst;
      state_d          = state_q;
      md_cnt_d         = md_cnt_q;

      if (rst) begin
         // Freeze the whole pipeline and fill every stage with NOPs
         hif.PCwrite      = 1'b0;
         hif.IF_IDwrite   = 1'b0;
         hif.ID_EXwrite   = 1'b0;
         hif.EX_MEMwrite  = 1'b0;
         hif.MEM_WBwrite  = 1'b0;
         hif.IF_IDflush   = 1'b1;
         hif.ID_EXflush   = 1'b1;
         hif.EX_MEMbubble = 1'b1;
         hif.MEM_WBbubble = 1'b1;
      end else if (mem_wait) begin
         // Everything up to MEM holds; a pending branch is replayed after the wait
         hif.PCwrite      = 1'b0;
         hif.IF_IDwrite   = 1'b0;
         hif.ID_EXwrite   = 1'b0;
         hif.EX_MEMwrite  = 1'b0;
         hif.MEM_WBbubble = 1'b1;
      end else if (state_q == MD_BUSY) begin
         if (md_cnt_q != '0) begin
            hif.PCwrite      = 1'b0;
            hif.IF_IDwrite   = 1'b0;
            hif.ID_EXwrite   = 1'b0;
            hif.EX_MEMbubble = 1'b1;
            md_cnt_d         = md_cnt_q - 1'b1;
         end else begin
            state_d = RUN;
         end
      end else if (hif.EX_branchTaken) begin
         // ID holds a wrong-path instruction, so this also cancels any load-use stall
         hif.IF_IDflush = 1'b1;
         hif.ID_EXflush = 1'b1;
      end else if (hif.ID_EXmulDiv) begin
         hif.mdStart = 1'b1;
         if (MD_LATENCY > 1) begin
            hif.PCwrite      = 1'b0;
            hif.IF_IDwrite   = 1'b0;
            hif.ID_EXwrite   = 1'b0;
            hif.EX_MEMbubble = 1'b1;
            state_d          = MD_BUSY;
            md_cnt_d         = MD_CNT_INIT;
         end
      end else if (load_use) begin
         hif.PCwrite    = 1'b0;
         hif.IF_IDwrite = 1'b0;
         hif.ID_EXflush = 1'b1;
      end
   end

   // State register and MUL/DIV occupancy counter; reset aborts any MUL/DIV
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= RUN;
         md_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         md_cnt_q <= md_cnt_d;
      end
   end

   assign stall_en = !hif.PCwrite;

   hazard_stall_counter #(
      .COUNT_W (COUNT_W)
   ) u_stall_counter (
      .clk   (clk),
      .rst   (rst),
      .en    (stall_en),
      .count (hif.stallCycles)
   );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: a table of single-cycle RUN-state vectors,
// hand-written MUL/DIV and reset sequences, then random stimulus. Two DUTs
// run in lock-step: MD_LATENCY=4 with a 32-bit counter, and MD_LATENCY=1
// with a 3-bit counter so saturation is reachable.
module tb_hazard_control_unit;
   import hazard_control_unit_pkg::*;

   localparam int LAT_A = 4;
   localparam int LAT_B = 1;
   localparam int CW_A  = 32;
   localparam int CW_B  = 3;
   localparam logic [63:0] MAX_A = (64'd1 << CW_A) - 64'd1;
   localparam logic [63:0] MAX_B = (64'd1 << CW_B) - 64'd1;

   // Output vector order:
   // {PCw, IF_IDw, ID_EXw, EX_MEMw, MEM_WBw, IF_IDflush, ID_EXflush, EX_MEMbub, MEM_WBbub, mdStart, mdBusy}
   localparam logic [10:0] O_NORM  = 11'b11111_0000_00;
   localparam logic [10:0] O_LU    = 11'b00111_0100_00;
   localparam logic [10:0] O_BR    = 11'b11111_1100_00;
   localparam logic [10:0] O_MW    = 11'b00001_0001_00;
   localparam logic [10:0] O_RST   = 11'b00000_1111_00;
   localparam logic [10:0] O_MDIN  = 11'b00011_0010_10;
   localparam logic [10:0] O_MDST  = 11'b00011_0010_01;
   localparam logic [10:0] O_MDEND = 11'b11111_0000_01;
   localparam logic [10:0] O_MDMW  = 11'b00001_0001_01;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       us1;
      logic       us2;
      logic [4:0] rd;
      logic       mem_read;
      logic       mul_div;
      logic       br;
      logic       mem_access;
      logic       ready;
   } in_t;

   typedef struct {
      string       name;
      in_t         stim;
      logic [10:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hazard_control_unit_if #(.COUNT_W(CW_A)) ia ();
   hazard_control_unit_if #(.COUNT_W(CW_B)) ib ();

   hazard_control_unit #(.MD_LATENCY(LAT_A), .COUNT_W(CW_A)) dut_a (
      .clk (clk),
      .rst (rst),
      .hif (ia)
   );

   hazard_control_unit #(.MD_LATENCY(LAT_B), .COUNT_W(CW_B)) dut_b (
      .clk (clk),
      .rst (rst),
      .hif (ib)
   );

   int          vectors = 0;
   int          miscompares = 0;
   // Model state: EX cycles the current MUL/DIV still has to spend after this one
   int          rem_a = 0;
   int          rem_b = 0;
   logic [63:0] cnt_a = '0;
   logic [63:0] cnt_b = '0;

   function automatic in_t mk(input int rs1, input int rs2, input bit us1, input bit us2,
                              input int rd, input bit mr, input bit md, input bit br,
                              input bit ma, input bit rdy);
      in_t v;
      v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.us1 = us1; v.us2 = us2; v.rd = 5'(rd);
      v.mem_read = mr; v.mul_div = md; v.br = br; v.mem_access = ma; v.ready = rdy;
      return v;
   endfunction

   // Behavioural reference: one cycle of the hazard rules
   function automatic void model(input int lat, input int rem, input in_t v,
                                 output logic [10:0] o, output int rem_n);
      bit busy;
      bit mem_wait;
      bit lu;
      busy     = (rem > 0);
      mem_wait = v.mem_access && !v.ready;
      lu       = v.mem_read && (v.rd != 0) &&
                 ((v.us1 && v.rd == v.rs1) || (v.us2 && v.rd == v.rs2));
      rem_n    = rem;
      o        = O_NORM;
      if (mem_wait) begin
         o = busy ? O_MDMW : O_MW;
      end else if (busy) begin
         o     = (rem > 1) ? O_MDST : O_MDEND;
         rem_n = rem - 1;
      end else if (v.br) begin
         o = O_BR;
      end else if (v.mul_div) begin
         rem_n = lat - 1;
         o     = (lat > 1) ? O_MDIN : 11'b11111_0000_10;
      end else if (lu) begin
         o = O_LU;
      end
   endfunction

   task automatic drive(input in_t v);
      ia.IF_IDrs1 = v.rs1; ia.IF_IDrs2 = v.rs2; ia.IF_IDusesRs1 = v.us1; ia.IF_IDusesRs2 = v.us2;
      ia.ID_EXrd = v.rd; ia.ID_EXmemRead = v.mem_read; ia.ID_EXmulDiv = v.mul_div;
      ia.EX_branchTaken = v.br; ia.EX_MEMmemAccess = v.mem_access; ia.dmemReady = v.ready;
      ib.IF_IDrs1 = v.rs1; ib.IF_IDrs2 = v.rs2; ib.IF_IDusesRs1 = v.us1; ib.IF_IDusesRs2 = v.us2;
      ib.ID_EXrd = v.rd; ib.ID_EXmemRead = v.mem_read; ib.ID_EXmulDiv = v.mul_div;
      ib.EX_branchTaken = v.br; ib.EX_MEMmemAccess = v.mem_access; ib.dmemReady = v.ready;
   endtask

   function automatic logic [10:0] outs_a();
      return {ia.PCwrite, ia.IF_IDwrite, ia.ID_EXwrite, ia.EX_MEMwrite, ia.MEM_WBwrite,
              ia.IF_IDflush, ia.ID_EXflush, ia.EX_MEMbubble, ia.MEM_WBbubble,
              ia.mdStart, ia.mdBusy};
   endfunction

   function automatic logic [10:0] outs_b();
      return {ib.PCwrite, ib.IF_IDwrite, ib.ID_EXwrite, ib.EX_MEMwrite, ib.MEM_WBwrite,
              ib.IF_IDflush, ib.ID_EXflush, ib.EX_MEMbubble, ib.MEM_WBbubble,
              ib.mdStart, ib.mdBusy};
   endfunction

   task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic check_cnt(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: stallCycles got %0d expected %0d", name, got, exp);
      end
   endtask

   // Apply one cycle of inputs, compare both DUTs to the model (and optionally a table value)
   task automatic step(input in_t v, input string name, input bit has_exp, input logic [10:0] exp_a);
      logic [10:0] oa;
      logic [10:0] ob;
      int          rn_a;
      int          rn_b;
      @(negedge clk);
      drive(v);
      #1;
      model(LAT_A, rem_a, v, oa, rn_a);
      model(LAT_B, rem_b, v, ob, rn_b);
      check({name, "/a"}, outs_a(), oa);
      check({name, "/b"}, outs_b(), ob);
      if (has_exp) check({name, "/table"}, outs_a(), exp_a);
      check_cnt({name, "/cnt_a"}, 64'(ia.stallCycles), cnt_a);
      check_cnt({name, "/cnt_b"}, 64'(ib.stallCycles), cnt_b);
      rem_a = rn_a;
      rem_b = rn_b;
      if (!oa[10] && cnt_a < MAX_A) cnt_a++;
      if (!ob[10] && cnt_b < MAX_B) cnt_b++;
   endtask

   task automatic do_reset(input string name);
      @(negedge clk);
      rst = 1'b1;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      #1;
      check({name, "/rst_a"}, outs_a(), O_RST);
      check({name, "/rst_b"}, outs_b(), O_RST);
      check_cnt({name, "/rst_cnt_a"}, 64'(ia.stallCycles), 64'd0);
      check_cnt({name, "/rst_cnt_b"}, 64'(ib.stallCycles), 64'd0);
      rem_a = 0; rem_b = 0; cnt_a = '0; cnt_b = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   vec_t tbl[$];
   in_t  idle;
   in_t  mul;
   in_t  mul_wait;
   in_t  lu5;

   initial begin
      idle     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      mul      = mk(1, 2, 1, 1, 3, 0, 1, 0, 0, 1);
      mul_wait = mk(1, 2, 1, 1, 3, 0, 1, 0, 1, 0);
      lu5      = mk(1, 5, 1, 1, 5, 1, 0, 0, 0, 1);

      tbl.push_back('{"normal",            mk(1, 2, 1, 1, 3, 0, 0, 0, 0, 1), O_NORM});
      tbl.push_back('{"load_use_rs2",      lu5,                              O_LU});
      tbl.push_back('{"after_load_use",    mk(1, 2, 1, 1, 0, 0, 0, 0, 0, 1), O_NORM});
      tbl.push_back('{"load_x0",           mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 1), O_NORM});
      tbl.push_back('{"lu_and_branch",     mk(5, 1, 1, 0, 5, 1, 0, 1, 0, 1), O_BR});
      tbl.push_back('{"rs1_not_used",      mk(5, 1, 0, 1, 5, 1, 0, 0, 0, 1), O_NORM});
      tbl.push_back('{"load_use_rs1",      mk(7, 1, 1, 0, 7, 1, 0, 0, 0, 1), O_LU});
      tbl.push_back('{"mem_wait",          mk(1, 2, 1, 1, 3, 0, 0, 0, 1, 0), O_MW});
      tbl.push_back('{"mem_wait_branch",   mk(1, 2, 1, 1, 3, 0, 0, 1, 1, 0), O_MW});
      tbl.push_back('{"branch_after_wait", mk(1, 2, 1, 1, 3, 0, 0, 1, 1, 1), O_BR});
      tbl.push_back('{"mem_ready",         mk(1, 2, 1, 1, 3, 0, 0, 0, 1, 1), O_NORM});

      drive(idle);
      do_reset("init");

      foreach (tbl[i]) step(tbl[i].stim, tbl[i].name, 1'b1, tbl[i].exp);

      // MUL/DIV: entry, two busy bubbles, advance on the 4th EX cycle
      step(mul,  "md_entry",   1'b1, O_MDIN);
      step(mul,  "md_busy2",   1'b1, O_MDST);
      step(mul,  "md_busy1",   1'b1, O_MDST);
      step(mul,  "md_done",    1'b1, O_MDEND);
      step(idle, "md_after",   1'b1, O_NORM);

      // MUL/DIV with two memory wait cycles in the middle: 6 EX cycles total
      step(mul,      "mdw_entry", 1'b1, O_MDIN);
      step(mul,      "mdw_busy",  1'b1, O_MDST);
      step(mul_wait, "mdw_wait1", 1'b1, O_MDMW);
      step(mul_wait, "mdw_wait2", 1'b1, O_MDMW);
      step(mul,      "mdw_busy1", 1'b1, O_MDST);
      step(mul,      "mdw_done",  1'b1, O_MDEND);
      step(idle,     "mdw_after", 1'b1, O_NORM);

      // Reset in the middle of MD_BUSY, then a fresh MUL must start again
      step(mul, "mdr_entry", 1'b1, O_MDIN);
      step(mul, "mdr_busy",  1'b1, O_MDST);
      do_reset("mid_md");
      step(mul, "mdr_restart", 1'b1, O_MDIN);
      step(idle, "mdr_idle", 1'b0, O_NORM);
      step(idle, "mdr_idle2", 1'b0, O_NORM);
      step(idle, "mdr_idle3", 1'b0, O_NORM);

      // Sustained load-use: drives the 3-bit counter of dut_b into saturation
      for (int i = 0; i < 10; i++) step(lu5, "saturate", 1'b0, O_NORM);

      // Random traffic with small register numbers so dependencies are frequent
      for (int i = 0; i < 400; i++) begin
         in_t v;
         if (i == 200) do_reset("rand_rst");
         v = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 2) == 0), $urandom_range(0, 1));
         step(v, "random", 1'b0, O_NORM);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
